dff_pipeline: RTL and testbench

- Parametrised, elastic, bubble-collapsing register pipeline with a valid/ready handshake at both ends.
- Generalises a single posedge D flip-flop to WIDTH bits and DEPTH stages, adding backpressure, flush and an occupancy count.
- Used as the standard retiming/delay element between producer and consumer blocks on one clock domain.

---
 rtl/dff_pipeline.sv | 111 +++++++++++
 tb/tb_dff_pipeline.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dff_pipeline.sv
// -----------------------------------------------------------------------------
// dff_pipeline
//
// Elastic, bubble-collapsing register pipeline. This is a D flip-flop widened
// to WIDTH bits and DEPTH stages, with a handshake at both ends. It is the
// standard retiming and delay element between a producer and a consumer that
// share one clock.
//
// Handshake semantics (both ends): a transfer happens on a rising clk edge
// exactly when valid and ready are both high in the cycle before that edge.
// - A producer keeps data stable while valid is high and ready is low.
// - valid never waits on ready.
// - ready may depend combinationally on the far side. Here in_ready depends
//   on out_ready through a DEPTH-deep chain.
//
// Ports:
//   clk        clock; all state changes on posedge
//   rst_n      asynchronous active-low reset. It clears every valid bit and
//              loads RESET_VALUE into every data stage.
//   flush      synchronous clear of every valid bit. Data registers keep
//              their contents, and nothing is accepted in a flush cycle.
//   in_valid   producer presents in_data
//   in_ready   pipeline accepts in_data this cycle
//   in_data    input payload, WIDTH bits
//   out_valid  out_data holds a valid item
//   out_ready  consumer accepts out_data this cycle
//   out_data   output payload; this is the last stage register
//   occupancy  number of valid stages, 0..DEPTH
// -----------------------------------------------------------------------------
module dff_pipeline #(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  // Stage 0 is nearest the input and stage DEPTH-1 drives the output.
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] move;
  logic [WIDTH-1:0] d [DEPTH];
  logic             accept;

  // An item leaves stage i when the stage ahead is empty or is itself
  // emptying this cycle. The chain is resolved from the output backwards.
  // This lets bubbles collapse: items close up behind a stalled head.
  always_comb begin
    move = '0;
    move[DEPTH-1] = v[DEPTH-1] & out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      move[i] = v[i] & (~v[i+1] | move[i+1]);
    end
  end

  assign in_ready = ~flush & (~v[0] | move[0]);
  assign accept   = in_valid & in_ready;

  // Valid bits: flush outranks every move. A stage stays valid if it gets
  // a new item, or if it held one that did not leave.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
    end else if (flush) begin
      v <= '0;
    end else begin
      v[0] <= accept | (v[0] & ~move[0]);
      for (int i = 1; i < DEPTH; i++) begin
        v[i] <= move[i-1] | (v[i] & ~move[i]);
      end
    end
  end

  // Data registers load only when an item arrives. Otherwise they hold.
  // They keep stale contents after a flush or after the stage drains, so
  // out_data keeps its last value while the pipeline is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= RESET_VALUE;
      end
    end else if (!flush) begin
      if (accept) begin
        d[0] <= in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (move[i-1]) begin
          d[i] <= d[i-1];
        end
      end
    end
  end

  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

  always_comb begin
    occupancy = OCC_W'($countones(v));
  end

endmodule

// File: tb/tb_dff_pipeline.sv
// -----------------------------------------------------------------------------
// tb_dff_pipeline
//
// Drives two pipeline instances:
//   dut_a  WIDTH=8, DEPTH=4, RESET_VALUE=8'hA5
//   dut_b  WIDTH=1, DEPTH=1, RESET_VALUE=1'b1
// sel picks which instance receives traffic and is observed.
//
// The reference model keeps the in-flight items as a queue, oldest first.
// Each item carries the stage position it occupies. Every cycle, an item
// advances when the position ahead of it is free or is being vacated. The
// head leaves when it sits in the last stage and the consumer is ready.
// -----------------------------------------------------------------------------
module tb_dff_pipeline;

  // ---------------- clock / reset ----------------
  logic clk;
  logic clk_en;
  logic rst_n;

  initial clk = 1'b0;
  always #5 if (clk_en) clk = ~clk;

  // ---------------- stimulus signals ----------------
  logic       sel;
  logic       flush;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] in_data;

  logic       a_in_ready, a_out_valid;
  logic [7:0] a_out_data;
  logic [2:0] a_occ;
  logic       b_in_ready, b_out_valid;
  logic       b_out_data;
  logic       b_occ;

  dff_pipeline #(.WIDTH(8), .DEPTH(4), .RESET_VALUE(8'hA5)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush & ~sel),
    .in_valid  (in_valid & ~sel),
    .in_ready  (a_in_ready),
    .in_data   (in_data),
    .out_valid (a_out_valid),
    .out_ready (out_ready),
    .out_data  (a_out_data),
    .occupancy (a_occ)
  );

  dff_pipeline #(.WIDTH(1), .DEPTH(1), .RESET_VALUE(1'b1)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush & sel),
    .in_valid  (in_valid & sel),
    .in_ready  (b_in_ready),
    .in_data   (in_data[0]),
    .out_valid (b_out_valid),
    .out_ready (out_ready),
    .out_data  (b_out_data),
    .occupancy (b_occ)
  );

  logic        obs_valid, obs_ready;
  logic [7:0]  obs_data;
  logic [31:0] obs_occ;

  always_comb begin
    if (sel) begin
      obs_valid = b_out_valid;
      obs_ready = b_in_ready;
      obs_data  = {7'b0, b_out_data};
      obs_occ   = 32'(b_occ);
    end else begin
      obs_valid = a_out_valid;
      obs_ready = a_in_ready;
      obs_data  = a_out_data;
      obs_occ   = 32'(a_occ);
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int         checks;
  int         errs;
  int         m_depth;
  logic [7:0] m_mask;
  logic [7:0] m_reset;
  logic [7:0] m_last;       // value the last stage register should show
  logic [7:0] exp_q[$];     // items in flight, oldest first
  int         pos_q[$];     // stage position of each item in exp_q
  bit         mv[];
  logic       p_valid, p_ready;
  int         cyc, first_acc, first_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    pos_q.delete();
    m_last = m_reset;
  endtask

  task automatic predict();
    int n;
    n  = pos_q.size();
    mv = new[n];
    for (int k = 0; k < n; k++) begin
      if (k == 0) mv[k] = (pos_q[0] == m_depth - 1) ? out_ready : 1'b1;
      else        mv[k] = (pos_q[k-1] != pos_q[k] + 1) || mv[k-1];
    end
    p_valid = (n > 0) && (pos_q[0] == m_depth - 1);
    p_ready = !flush && ((n == 0) || (pos_q[n-1] != 0) || mv[n-1]);
  endtask

  task automatic model_step();
    logic [7:0] nq[$];
    int         np[$];
    if (flush) begin
      exp_q.delete();
      pos_q.delete();
    end else begin
      for (int k = 0; k < pos_q.size(); k++) begin
        if (mv[k]) begin
          if (pos_q[k] != m_depth - 1) begin
            nq.push_back(exp_q[k]);
            np.push_back(pos_q[k] + 1);
            if (pos_q[k] + 1 == m_depth - 1) m_last = exp_q[k];
          end
        end else begin
          nq.push_back(exp_q[k]);
          np.push_back(pos_q[k]);
        end
      end
      if (in_valid && p_ready) begin
        nq.push_back(in_data & m_mask);
        np.push_back(0);
        if (m_depth == 1) m_last = in_data & m_mask;
        if (first_acc < 0) first_acc = cyc;
      end
      exp_q = nq;
      pos_q = np;
    end
  endtask

  // One clock cycle.
  // - At negedge: check the outputs against the model.
  // - At posedge: advance the model.
  // - Inputs are changed by the caller at posedge+1.
  task automatic cycle();
    @(negedge clk);
    predict();
    chk("out_valid", 32'(obs_valid), 32'(p_valid));
    chk("in_ready",  32'(obs_ready), 32'(p_ready));
    chk("occupancy", obs_occ, 32'(pos_q.size()));
    chk("out_data",  32'(obs_data), 32'(m_last));
    if (p_valid && out_ready) chk("sb_order", 32'(obs_data), 32'(exp_q[0]));
    if (obs_valid && first_out < 0) first_out = cyc;
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic stream16();
    first_acc = -1;
    first_out = -1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_data = 8'(i);
      cycle();
    end
    in_valid = 1'b0;
    repeat (m_depth + 2) cycle();
    chk("latency", 32'(first_out - first_acc), 32'(m_depth));
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_data   = 8'($urandom_range(0, 255));
      cycle();
    end
    flush    = 1'b0;
    in_valid = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    checks    = 0;
    errs      = 0;
    cyc       = 0;
    first_acc = -1;
    first_out = -1;
    clk_en    = 1'b0;
    sel       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = 8'h00;
    m_depth   = 4;
    m_mask    = 8'hFF;
    m_reset   = 8'hA5;
    model_reset();

    // Reset takes effect with no clock running.
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", 32'(obs_valid), 32'h0);
    chk("rst_out_data",  32'(obs_data),  32'hA5);
    chk("rst_occupancy", obs_occ,        32'h0);
    chk("rst_in_ready",  32'(obs_ready), 32'h1);

    clk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Streaming at one item per cycle.
    stream16();

    // Backpressure: fill while the consumer is stalled, then drain.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = 8'(8'h11 * i);
      cycle();
    end
    in_data = 8'h99;
    cycle();
    chk("bp_occupancy", obs_occ,        32'd4);
    chk("bp_in_ready",  32'(obs_ready), 32'h0);
    chk("bp_out_data",  32'(obs_data),  32'h11);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) cycle();

    // Bubble collapse.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h55;
    cycle();
    in_valid = 1'b0;
    repeat (2) cycle();
    in_valid = 1'b1;
    in_data  = 8'h66;
    cycle();
    in_valid = 1'b0;
    repeat (3) cycle();
    chk("bubble_occupancy", obs_occ, 32'd2);
    out_ready = 1'b1;
    repeat (3) cycle();

    // Flush with a concurrent input that must be dropped.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'($urandom_range(0, 255));
      cycle();
    end
    chk("pre_flush_occupancy", obs_occ, 32'd3);
    flush   = 1'b1;
    in_data = 8'h77;
    cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_occupancy", obs_occ,        32'd0);
    chk("flush_out_valid", 32'(obs_valid), 32'h0);
    out_ready = 1'b1;
    repeat (5) cycle();

    // Asynchronous reset mid-stream, with two items in stages 3 and 2.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h3C;
    cycle();
    in_data = 8'h4D;
    cycle();
    in_valid = 1'b0;
    repeat (3) cycle();
    chk("pre_rst_out_valid", 32'(obs_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(obs_valid), 32'h0);
    chk("async_occupancy", obs_occ,        32'h0);
    chk("async_out_data",  32'(obs_data),  32'hA5);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    stream16();

    // Randomized traffic on the deep instance.
    random_run(300);
    out_ready = 1'b1;
    repeat (6) cycle();

    // Single-stage, single-bit instance.
    sel     = 1'b1;
    m_depth = 1;
    m_mask  = 8'h01;
    m_reset = 8'h01;
    model_reset();
    stream16();
    random_run(200);

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule
